plru_victim_sel: RTL and testbench



---
 rtl/cache_pkg.sv | 88 ++++++++
 rtl/first_zero_oh.sv | 22 ++
 rtl/plru_victim_sel.sv | 105 ++++++++++
 tb/tb_plru_victim_sel.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared tree pseudo-LRU helpers for cache replacement blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    // Helpers work on a maximum-size tree; callers zero-extend and slice.
    localparam int unsigned PLRU_MAX_WAYS   = 64;
    localparam int unsigned PLRU_TREE_W     = PLRU_MAX_WAYS - 1;
    localparam int unsigned PLRU_MAX_LEVELS = $clog2(PLRU_MAX_WAYS);

    typedef logic [PLRU_TREE_W-1:0]   plru_tree_t;
    typedef logic [PLRU_MAX_WAYS-1:0] plru_way_oh_t;

    function automatic int unsigned plru_levels(input int unsigned num_ways);
        int unsigned levels;
        levels = 0;
        for (int unsigned l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if ((32'd1 << l) < num_ways) begin
                levels++;
            end
        end
        return levels;
    endfunction

    function automatic plru_way_oh_t plru_victim(input plru_tree_t  tree,
                                                 input int unsigned num_ways);
        int unsigned levels;
        int unsigned node;
        plru_tree_t  v_shift;
        levels = plru_levels(num_ways);
        node   = 0;
        for (int unsigned l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < levels) begin
                v_shift = tree >> node;
                node    = 2 * node + (v_shift[0] ? 32'd2 : 32'd1);
            end
        end
        return plru_way_oh_t'(1) << (node - (num_ways - 1));
    endfunction

    // Lowest set bit of way_oh wins; an all-zero way_oh leaves the tree as is.
    function automatic plru_tree_t plru_update(input plru_tree_t   tree,
                                               input plru_way_oh_t way_oh,
                                               input int unsigned  num_ways);
        int unsigned  levels;
        int unsigned  node;
        int unsigned  way;
        int unsigned  dir;
        logic         found;
        plru_tree_t   v_tree;
        plru_tree_t   v_mask;
        plru_way_oh_t v_oh;
        v_tree = tree;
        found  = 1'b0;
        way    = 0;
        for (int unsigned i = PLRU_MAX_WAYS; i > 0; i--) begin
            v_oh = way_oh >> (i - 1);
            if (v_oh[0]) begin
                way   = i - 1;
                found = 1'b1;
            end
        end
        if (found) begin
            levels = plru_levels(num_ways);
            node   = 0;
            for (int unsigned l = 0; l < PLRU_MAX_LEVELS; l++) begin
                if (l < levels) begin
                    dir    = (way >> (levels - 1 - l)) & 32'd1;
                    v_mask = plru_tree_t'(1) << node;
                    if (dir == 0) begin
                        v_tree = v_tree | v_mask;
                    end else begin
                        v_tree = v_tree & ~v_mask;
                    end
                    node = 2 * node + 1 + dir;
                end
            end
        end
        return v_tree;
    endfunction

endpackage

`default_nettype wire

// File: rtl/first_zero_oh.sv
// ============================================================================
// Module      : first_zero_oh
// Description : One-hot marker of the lowest-index zero bit of a vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module first_zero_oh #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_oh,
    output logic             o_found
);

    // Adding one ripples through the trailing ones and lands on the first zero.
    assign o_oh    = ~i_vec & (i_vec + WIDTH'(1));
    assign o_found = ~&i_vec;

endmodule

`default_nettype wire

// File: rtl/plru_victim_sel.sv
// ============================================================================
// Module      : plru_victim_sel
// Description : Per-set tree pseudo-LRU victim selector with invalid-way
//               priority. Define PLRU_FWD_EN to forward a same-cycle,
//               same-set access into the lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned NUM_SETS = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        lookup_valid_i,
    input  logic [$clog2(NUM_SETS)-1:0] lookup_set_i,
    input  logic [NUM_WAYS-1:0]         way_valid_i,
    output logic                        victim_valid_o,
    output logic [NUM_WAYS-1:0]         victim_oh_o,
    input  logic                        access_valid_i,
    input  logic [$clog2(NUM_SETS)-1:0] access_set_i,
    input  logic [NUM_WAYS-1:0]         access_way_oh_i
);

    localparam int unsigned C_TREE_W = NUM_WAYS - 1;

    function automatic logic [NUM_WAYS-1:0] tree_victim(input logic [C_TREE_W-1:0] tree);
        plru_way_oh_t v_full;
        v_full = plru_victim(plru_tree_t'(tree), NUM_WAYS);
        return v_full[NUM_WAYS-1:0];
    endfunction

    function automatic logic [C_TREE_W-1:0] tree_update(input logic [C_TREE_W-1:0] tree,
                                                        input logic [NUM_WAYS-1:0] way_oh);
        plru_tree_t v_full;
        v_full = plru_update(plru_tree_t'(tree), plru_way_oh_t'(way_oh), NUM_WAYS);
        return v_full[C_TREE_W-1:0];
    endfunction

    logic [C_TREE_W-1:0] r_tree [NUM_SETS];
    logic                r_victim_valid;
    logic [NUM_WAYS-1:0] r_victim_oh;

    logic [C_TREE_W-1:0] w_tree_acc_new;
    logic [C_TREE_W-1:0] w_tree_lkp;
    logic [NUM_WAYS-1:0] w_plru_oh;
    logic [NUM_WAYS-1:0] w_inv_oh;
    logic                w_any_inv;
    logic [NUM_WAYS-1:0] w_victim_oh;

    assign w_tree_acc_new = tree_update(r_tree[access_set_i], access_way_oh_i);

    always_comb begin
        w_tree_lkp = r_tree[lookup_set_i];
`ifdef PLRU_FWD_EN
        if (access_valid_i && (access_set_i == lookup_set_i)) begin
            w_tree_lkp = w_tree_acc_new;
        end
`endif
    end

    assign w_plru_oh = tree_victim(w_tree_lkp);

    first_zero_oh #(
        .WIDTH   (NUM_WAYS)
    ) u_first_zero_oh (
        .i_vec   (way_valid_i),
        .o_oh    (w_inv_oh),
        .o_found (w_any_inv)
    );

    // Filling an empty way always beats evicting a live one.
    assign w_victim_oh = w_any_inv ? w_inv_oh : w_plru_oh;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_tree[s] <= '0;
            end
        end else if (access_valid_i) begin
            r_tree[access_set_i] <= w_tree_acc_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_victim_valid <= 1'b0;
            r_victim_oh    <= '0;
        end else begin
            r_victim_valid <= lookup_valid_i;
            if (lookup_valid_i) begin
                r_victim_oh <= w_victim_oh;
            end
        end
    end

    assign victim_valid_o = r_victim_valid;
    assign victim_oh_o    = r_victim_oh;

endmodule

`default_nettype wire

// File: tb/tb_plru_victim_sel.sv
// ============================================================================
// Module      : tb_plru_victim_sel
// Description : Scoreboard bench for plru_victim_sel against a range-walking
//               reference model (NUM_WAYS=4, NUM_SETS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plru_victim_sel;

    localparam int NW = 4;
    localparam int NS = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          lookup_valid_i = 1'b0;
    logic [SW-1:0] lookup_set_i = '0;
    logic [NW-1:0] way_valid_i = '1;
    logic          victim_valid_o;
    logic [NW-1:0] victim_oh_o;
    logic          access_valid_i = 1'b0;
    logic [SW-1:0] access_set_i = '0;
    logic [NW-1:0] access_way_oh_i = '0;

    always #5 clk = ~clk;

    plru_victim_sel #(
        .NUM_WAYS        (NW),
        .NUM_SETS        (NS)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_set_i    (lookup_set_i),
        .way_valid_i     (way_valid_i),
        .victim_valid_o  (victim_valid_o),
        .victim_oh_o     (victim_oh_o),
        .access_valid_i  (access_valid_i),
        .access_set_i    (access_set_i),
        .access_way_oh_i (access_way_oh_i)
    );

    typedef struct {
        int            due;
        logic [NW-1:0] oh;
    } exp_t;

    exp_t          sb[$];
    int            model [NS][NW-1];
    logic [NW-1:0] last_oh = '0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Victim: walk a shrinking [lo,hi) way range; bit 0 keeps the left half.
    function automatic logic [NW-1:0] model_victim(input int s, input logic [NW-1:0] v);
        logic [NW-1:0] one;
        int lo, hi, n, mid;
        one = 1;
        for (int i = 0; i < NW; i++) begin
            if (!v[i]) return one << i;
        end
        lo = 0; hi = NW; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (model[s][n] == 0) begin hi = mid; n = 2 * n + 1; end
            else begin lo = mid; n = 2 * n + 2; end
        end
        return one << lo;
    endfunction

    task automatic model_update(input int s, input logic [NW-1:0] oh);
        int w, lo, hi, n, mid;
        w = -1;
        for (int i = NW - 1; i >= 0; i--) if (oh[i]) w = i;
        if (w < 0) return;
        lo = 0; hi = NW; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin model[s][n] = 1; hi = mid; n = 2 * n + 1; end
            else begin model[s][n] = 0; lo = mid; n = 2 * n + 2; end
        end
    endtask

    task automatic model_clear();
        foreach (model[s, n]) model[s][n] = 0;
    endtask

    // Monitor: one expected pulse per due cycle, otherwise idle with held output.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            check("rst_valid", NW'(victim_valid_o), '0);
            check("rst_oh", victim_oh_o, '0);
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL missing_pulse: got none, expected %b due cyc %0d", e.oh, e.due);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("pulse_valid", NW'(victim_valid_o), NW'(1));
                check("victim", victim_oh_o, e.oh);
                last_oh = e.oh;
            end else begin
                check("idle_valid", NW'(victim_valid_o), '0);
                check("hold_oh", victim_oh_o, last_oh);
            end
        end
    end

    // One clock of stimulus; a lookup pushes its expected victim.
    task automatic step(input logic lv, input int lset, input logic [NW-1:0] vv,
                        input logic av, input int aset, input logic [NW-1:0] aoh,
                        input logic use_exp, input logic [NW-1:0] exp);
        exp_t e;
        lookup_valid_i  = lv;
        lookup_set_i    = SW'(lset);
        way_valid_i     = vv;
        access_valid_i  = av;
        access_set_i    = SW'(aset);
        access_way_oh_i = aoh;
`ifdef PLRU_FWD_EN
        if (av) model_update(aset, aoh);
        e.oh = model_victim(lset, vv);
`else
        e.oh = model_victim(lset, vv);
        if (av) model_update(aset, aoh);
`endif
        if (use_exp) e.oh = exp;
        e.due = cyc + 1;
        if (lv) sb.push_back(e);
        @(posedge clk); #1;
        lookup_valid_i = 1'b0;
        access_valid_i = 1'b0;
    endtask

    task automatic lookup(input int s, input logic [NW-1:0] vv, input logic [NW-1:0] exp);
        step(1'b1, s, vv, 1'b0, 0, '0, 1'b1, exp);
    endtask

    task automatic touch(input int s, input logic [NW-1:0] oh);
        step(1'b0, 0, '1, 1'b1, s, oh, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        sb.delete();
        last_oh = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected summary before t=200000");
        $fatal(1);
    end

    initial begin
        logic [NW-1:0] fwd_exp;
        logic [NW-1:0] aoh;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        lookup(0, 4'b1111, 4'b0001);
        touch(0, 4'b0001);
        lookup(0, 4'b1111, 4'b0100);
        touch(0, 4'b0100);
        lookup(0, 4'b1111, 4'b0010);
        lookup(0, 4'b1011, 4'b0100);
        lookup(0, 4'b0000, 4'b0001);

        do_reset();
`ifdef PLRU_FWD_EN
        fwd_exp = 4'b0100;
`else
        fwd_exp = 4'b0001;
`endif
        step(1'b1, 0, 4'b1111, 1'b1, 0, 4'b0001, 1'b1, fwd_exp);
        lookup(0, 4'b1111, 4'b0100);

        do_reset();
        touch(1, 4'b1000);
        lookup(0, 4'b1111, 4'b0001);
        touch(0, 4'b0000);
        lookup(0, 4'b1111, 4'b0001);
        touch(2, 4'b0110);
        lookup(2, 4'b1111, 4'b0100);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       aoh = 4'b0000;
                1:       aoh = NW'($urandom_range(1, 15));
                default: aoh = NW'(1) << $urandom_range(0, NW - 1);
            endcase
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
                 ($urandom_range(0, 3) == 0) ? NW'($urandom_range(0, 15)) : 4'b1111,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)), aoh,
                 1'b0, '0);
        end

        // Reset lands in the cycle the last lookup's pulse is on the outputs.
        touch(3, 4'b0001);
        step(1'b1, 3, 4'b1111, 1'b0, 0, '0, 1'b0, '0);
        #1;
        check("pre_rst_valid", NW'(victim_valid_o), NW'(1));
        lookup_valid_i = 1'b1;
        lookup_set_i   = 2'd1;
        rst_ni         = 1'b0;
        sb.delete();
        last_oh = '0;
        model_clear();
        #1;
        check("rst_drop_valid", NW'(victim_valid_o), '0);
        check("rst_drop_oh", victim_oh_o, '0);
        repeat (2) @(posedge clk);
        #1;
        lookup_valid_i = 1'b0;
        rst_ni = 1'b1;
        for (int s = 0; s < NS; s++) lookup(s, 4'b1111, 4'b0001);

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
